// File: rtl/fifo_sync_ext.sv
// Single-clock FIFO with simultaneous read/write, optional first-word-fall-through,
// programmable almost-full/almost-empty flags, occupancy count and sticky error flags.
module fifo_sync_ext #(
  parameter int DATA_WIDTH          = 8,
  parameter int FIFO_DEPTH          = 16,
  parameter int COUNT_WIDTH         = 5,
  parameter int FWFT_MODE           = 0,
  parameter int ALMOST_FULL_THRESH  = 14,
  parameter int ALMOST_EMPTY_THRESH = 2
) (
  input  logic                   clkIn,
  input  logic                   rstIn,
  input  logic                   wrEnIn,
  input  logic [DATA_WIDTH-1:0]  wrDataIn,
  input  logic                   rdEnIn,
  input  logic                   clrErrIn,
  output logic [DATA_WIDTH-1:0]  rdDataOut,
  output logic                   rdValidOut,
  output logic                   isEmptyOut,
  output logic                   isFullOut,
  output logic                   isAlmostEmptyOut,
  output logic                   isAlmostFullOut,
  output logic [COUNT_WIDTH-1:0] dataCountOut,
  output logic                   overflowOut,
  output logic                   underflowOut
);

  localparam int PTR_WIDTH = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [COUNT_WIDTH-1:0] DEPTH_CNT = COUNT_WIDTH'(FIFO_DEPTH);
  localparam logic [COUNT_WIDTH-1:0] AF_CNT    = COUNT_WIDTH'(ALMOST_FULL_THRESH);
  localparam logic [COUNT_WIDTH-1:0] AE_CNT    = COUNT_WIDTH'(ALMOST_EMPTY_THRESH);
  localparam logic [PTR_WIDTH-1:0]   LAST_PTR  = PTR_WIDTH'(FIFO_DEPTH - 1);

  logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]   wrPtr;
  logic [PTR_WIDTH-1:0]   rdPtr;
  logic [COUNT_WIDTH-1:0] count;
  logic                   wrAcc;
  logic                   rdAcc;

  // Handshake: a request (wrEnIn / rdEnIn) is sampled on every rising edge and
  // transfers a word only when its accept (wrAcc / rdAcc) is high at that edge;
  // a full FIFO takes a write only if a read frees a slot in the same cycle.
  assign rdAcc = rdEnIn & (count != '0);
  assign wrAcc = wrEnIn & ((count < DEPTH_CNT) | rdAcc);

  assign dataCountOut     = count;
  assign isEmptyOut       = (count == '0);
  assign isFullOut        = (count == DEPTH_CNT);
  assign isAlmostEmptyOut = (count <= AE_CNT);
  assign isAlmostFullOut  = (count >= AF_CNT);

  // Storage is deliberately not reset.
  always_ff @(posedge clkIn) begin
    if (wrAcc) mem[wrPtr] <= wrDataIn;
  end

  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (wrAcc) wrPtr <= (wrPtr == LAST_PTR) ? '0 : wrPtr + 1'b1;
      if (rdAcc) rdPtr <= (rdPtr == LAST_PTR) ? '0 : rdPtr + 1'b1;
      case ({wrAcc, rdAcc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A new error in the same cycle wins over a clear request.
  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      overflowOut  <= 1'b0;
      underflowOut <= 1'b0;
    end else begin
      if (wrEnIn && !wrAcc)  overflowOut <= 1'b1;
      else if (clrErrIn)     overflowOut <= 1'b0;
      if (rdEnIn && !rdAcc)  underflowOut <= 1'b1;
      else if (clrErrIn)     underflowOut <= 1'b0;
    end
  end

  generate
    if (FWFT_MODE != 0) begin : gFwft
      // Head word is presented directly; masked to zero while empty.
      assign rdDataOut  = isEmptyOut ? '0 : mem[rdPtr];
      assign rdValidOut = !isEmptyOut;
    end else begin : gStd
      logic [DATA_WIDTH-1:0] rdDataQ;
      logic                  rdValidQ;
      always_ff @(posedge clkIn) begin
        if (rstIn) begin
          rdDataQ  <= '0;
          rdValidQ <= 1'b0;
        end else begin
          rdValidQ <= rdAcc;
          if (rdAcc) rdDataQ <= mem[rdPtr];
        end
      end
      assign rdDataOut  = rdDataQ;
      assign rdValidOut = rdValidQ;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_sync_ext.sv
// Directed bench for fifo_sync_ext: a standard-read instance and an FWFT instance
// share one stimulus stream; each scenario task checks its own expectations.
module tb_fifo_sync_ext;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic       clr_err;

  logic [7:0] d0_rd_data, d1_rd_data;
  logic       d0_rd_valid, d1_rd_valid;
  logic       d0_empty, d0_full, d0_aempty, d0_afull;
  logic       d1_empty, d1_full, d1_aempty, d1_afull;
  logic [4:0] d0_count, d1_count;
  logic       d0_ovf, d0_unf, d1_ovf, d1_unf;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_word;

  fifo_sync_ext #(.FWFT_MODE(0)) dut0 (
    .clkIn(clk), .rstIn(rst), .wrEnIn(wr_en), .wrDataIn(wr_data), .rdEnIn(rd_en),
    .clrErrIn(clr_err), .rdDataOut(d0_rd_data), .rdValidOut(d0_rd_valid),
    .isEmptyOut(d0_empty), .isFullOut(d0_full), .isAlmostEmptyOut(d0_aempty),
    .isAlmostFullOut(d0_afull), .dataCountOut(d0_count), .overflowOut(d0_ovf),
    .underflowOut(d0_unf)
  );

  fifo_sync_ext #(.FWFT_MODE(1)) dut1 (
    .clkIn(clk), .rstIn(rst), .wrEnIn(wr_en), .wrDataIn(wr_data), .rdEnIn(rd_en),
    .clrErrIn(clr_err), .rdDataOut(d1_rd_data), .rdValidOut(d1_rd_valid),
    .isEmptyOut(d1_empty), .isFullOut(d1_full), .isAlmostEmptyOut(d1_aempty),
    .isAlmostFullOut(d1_afull), .dataCountOut(d1_count), .overflowOut(d1_ovf),
    .underflowOut(d1_unf)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wr_data = 8'h00;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  // driver: apply one cycle of inputs, return 1 time unit after the edge
  task automatic drive(input logic wr, input logic [7:0] d, input logic rd, input logic clr);
    wr_en = wr; wr_data = d; rd_en = rd; clr_err = clr;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (d0_count !== 5'd0)   begin failures++; $display("FAIL reset_count got=%0d exp=0", d0_count); end
    checks++; if ({d0_empty, d0_full, d0_aempty, d0_afull} !== 4'b1010)
      begin failures++; $display("FAIL reset_flags got=%b exp=1010", {d0_empty, d0_full, d0_aempty, d0_afull}); end
    checks++; if ({d0_rd_valid, d0_rd_data} !== 9'h000)
      begin failures++; $display("FAIL reset_rd got=%h exp=000", {d0_rd_valid, d0_rd_data}); end
    checks++; if ({d0_ovf, d0_unf, d1_ovf, d1_unf} !== 4'b0000)
      begin failures++; $display("FAIL reset_err got=%b exp=0000", {d0_ovf, d0_unf, d1_ovf, d1_unf}); end
    checks++; if ({d1_rd_valid, d1_rd_data} !== 9'h000)
      begin failures++; $display("FAIL reset_fwft_rd got=%h exp=000", {d1_rd_valid, d1_rd_data}); end
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b0);
      exp_q.push_back(8'(i));
    end
    checks++; if (d0_full !== 1'b1 || d0_count !== 5'd16)
      begin failures++; $display("FAIL fill_full got=%b/%0d exp=1/16", d0_full, d0_count); end
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      exp_word = exp_q.pop_front();
      checks++; if (d0_rd_valid !== 1'b1 || d0_rd_data !== exp_word)
        begin failures++; $display("FAIL drain_data[%0d] got=%b/%h exp=1/%h", i, d0_rd_valid, d0_rd_data, exp_word); end
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    checks++; if (d0_rd_valid !== 1'b0 || d0_rd_data !== 8'h10)
      begin failures++; $display("FAIL drain_hold got=%b/%h exp=0/10", d0_rd_valid, d0_rd_data); end
    checks++; if (d0_empty !== 1'b1 || d0_ovf !== 1'b0)
      begin failures++; $display("FAIL drain_end got=%b/%b exp=1/0", d0_empty, d0_ovf); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
      exp_q.push_back(8'h20 + 8'(i));
    end
    drive(1'b1, 8'hAA, 1'b0, 1'b0);
    checks++; if (d0_ovf !== 1'b1 || d0_count !== 5'd16)
      begin failures++; $display("FAIL ovf_set got=%b/%0d exp=1/16", d0_ovf, d0_count); end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    checks++; if (d0_ovf !== 1'b0)
      begin failures++; $display("FAIL ovf_clear got=%b exp=0", d0_ovf); end
    drive(1'b1, 8'hAB, 1'b0, 1'b1);
    checks++; if (d0_ovf !== 1'b1)
      begin failures++; $display("FAIL ovf_set_beats_clear got=%b exp=1", d0_ovf); end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      exp_word = exp_q.pop_front();
      checks++; if (d0_rd_data !== exp_word)
        begin failures++; $display("FAIL ovf_drain[%0d] got=%h exp=%h", i, d0_rd_data, exp_word); end
    end
    checks++; if (d0_empty !== 1'b1 || d0_ovf !== 1'b0)
      begin failures++; $display("FAIL ovf_end got=%b/%b exp=1/0", d0_empty, d0_ovf); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b0);
      exp_q.push_back(8'(i));
    end
    // 20 cycles of simultaneous write+read while full, crossing the pointer wrap
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 8'd16 + 8'(i), 1'b1, 1'b0);
      exp_q.push_back(8'd16 + 8'(i));
      exp_word = exp_q.pop_front();
      checks++; if (d0_count !== 5'd16 || d0_full !== 1'b1 || d0_ovf !== 1'b0)
        begin failures++; $display("FAIL b2b_full[%0d] got=%0d/%b/%b exp=16/1/0", i, d0_count, d0_full, d0_ovf); end
      checks++; if (d0_rd_valid !== 1'b1 || d0_rd_data !== exp_word)
        begin failures++; $display("FAIL b2b_data[%0d] got=%b/%h exp=1/%h", i, d0_rd_valid, d0_rd_data, exp_word); end
    end
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      exp_word = exp_q.pop_front();
      checks++; if (d0_rd_data !== exp_word)
        begin failures++; $display("FAIL b2b_drain[%0d] got=%h exp=%h", i, d0_rd_data, exp_word); end
    end
    checks++; if (d0_empty !== 1'b1)
      begin failures++; $display("FAIL b2b_empty got=%b exp=1", d0_empty); end
  endtask

  task automatic test_empty_rw();
    do_reset();
    drive(1'b1, 8'h55, 1'b1, 1'b0);
    checks++; if (d0_unf !== 1'b1 || d0_count !== 5'd1 || d0_rd_valid !== 1'b0)
      begin failures++; $display("FAIL empty_rw got=%b/%0d/%b exp=1/1/0", d0_unf, d0_count, d0_rd_valid); end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (d0_rd_valid !== 1'b1 || d0_rd_data !== 8'h55 || d0_count !== 5'd0)
      begin failures++; $display("FAIL empty_rw_read got=%b/%h/%0d exp=1/55/0", d0_rd_valid, d0_rd_data, d0_count); end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    checks++; if (d0_unf !== 1'b0)
      begin failures++; $display("FAIL unf_clear got=%b exp=0", d0_unf); end
  endtask

  task automatic test_fwft();
    do_reset();
    drive(1'b1, 8'h3C, 1'b0, 1'b0);
    checks++; if (d1_rd_valid !== 1'b1 || d1_rd_data !== 8'h3C)
      begin failures++; $display("FAIL fwft_show got=%b/%h exp=1/3c", d1_rd_valid, d1_rd_data); end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (d1_rd_valid !== 1'b0 || d1_count !== 5'd0)
      begin failures++; $display("FAIL fwft_pop got=%b/%0d exp=0/0", d1_rd_valid, d1_count); end
    drive(1'b1, 8'h11, 1'b0, 1'b0);
    drive(1'b1, 8'h22, 1'b0, 1'b0);
    checks++; if (d1_rd_data !== 8'h11 || d1_count !== 5'd2)
      begin failures++; $display("FAIL fwft_head got=%h/%0d exp=11/2", d1_rd_data, d1_count); end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (d1_rd_valid !== 1'b1 || d1_rd_data !== 8'h22)
      begin failures++; $display("FAIL fwft_next got=%b/%h exp=1/22", d1_rd_valid, d1_rd_data); end
  endtask

  task automatic test_thresholds();
    logic exp_ae, exp_af;
    do_reset();
    for (int n = 1; n <= 16; n++) begin
      drive(1'b1, 8'(n), 1'b0, 1'b0);
      exp_ae = (n <= 2); exp_af = (n >= 14);
      checks++; if (d0_count !== 5'(n) || d0_aempty !== exp_ae || d0_afull !== exp_af)
        begin failures++; $display("FAIL thr_up[%0d] got=%0d/%b/%b exp=%0d/%b/%b", n, d0_count, d0_aempty, d0_afull, n, exp_ae, exp_af); end
    end
    for (int n = 15; n >= 0; n--) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      exp_ae = (n <= 2); exp_af = (n >= 14);
      checks++; if (d0_count !== 5'(n) || d0_aempty !== exp_ae || d0_afull !== exp_af)
        begin failures++; $display("FAIL thr_down[%0d] got=%0d/%b/%b exp=%0d/%b/%b", n, d0_count, d0_aempty, d0_afull, n, exp_ae, exp_af); end
    end
    // leave sticky, read and occupancy state dirty, then reset at count 9
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    for (int n = 0; n < 10; n++) drive(1'b1, 8'h40 + 8'(n), 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (d0_count !== 5'd9 || d0_unf !== 1'b1 || d0_rd_data !== 8'h40)
      begin failures++; $display("FAIL pre_reset got=%0d/%b/%h exp=9/1/40", d0_count, d0_unf, d0_rd_data); end
    do_reset();
    checks++; if ({d0_count, d0_empty, d0_full, d0_aempty, d0_afull} !== {5'd0, 4'b1010})
      begin failures++; $display("FAIL mid_reset_flags got=%0d/%b exp=0/1010", d0_count, {d0_empty, d0_full, d0_aempty, d0_afull}); end
    checks++; if ({d0_rd_valid, d0_rd_data, d0_ovf, d0_unf} !== 11'h000)
      begin failures++; $display("FAIL mid_reset_rd got=%b/%h/%b/%b exp=0/00/0/0", d0_rd_valid, d0_rd_data, d0_ovf, d0_unf); end
    drive(1'b1, 8'h77, 1'b0, 1'b0);
    checks++; if (d0_count !== 5'd1 || d1_rd_data !== 8'h77)
      begin failures++; $display("FAIL post_reset_write got=%0d/%h exp=1/77", d0_count, d1_rd_data); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_back_to_back();
    test_empty_rw();
    test_fwft();
    test_thresholds();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_sync_ext.md
Name: fifo_sync_ext

Overview:
- Parametrised next-generation synchronous FIFO for single-clock datapaths.
- Adds the following over the existing sync FIFO:
  - simultaneous read and write in the same cycle;
  - a first-word-fall-through (FWFT) mode;
  - programmable almost-full and almost-empty flags;
  - an occupancy count output;
  - sticky overflow and underflow error flags.
- Drop-in buffer between producer and consumer blocks that need flow-control margin.

Parameters:
- DATA_WIDTH, 8: width of each stored word.
- FIFO_DEPTH, 16: number of entries. Any integer >= 2; power of 2 not required.
- COUNT_WIDTH, 5: width of dataCountOut. Must be >= clog2(FIFO_DEPTH+1).
- FWFT_MODE, 0: read mode. 0 = standard registered read; 1 = first-word-fall-through.
- ALMOST_FULL_THRESH, 14: isAlmostFullOut is asserted when count >= this value. Range 1..FIFO_DEPTH.
- ALMOST_EMPTY_THRESH, 2: isAlmostEmptyOut is asserted when count <= this value. Range 0..FIFO_DEPTH-1.

Ports:
- clkIn  in  1  clock; all logic on rising edge
- rstIn  in  1  synchronous, active-high reset
- wrEnIn  in  1  write request
- wrDataIn  in  DATA_WIDTH  write data
- rdEnIn  in  1  read request (standard mode) / pop of head word (FWFT mode)
- clrErrIn  in  1  clears the sticky error flags
- rdDataOut  out  DATA_WIDTH  read data
- rdValidOut  out  1  rdDataOut holds valid data
- isEmptyOut  out  1  count == 0
- isFullOut  out  1  count == FIFO_DEPTH
- isAlmostEmptyOut  out  1  count <= ALMOST_EMPTY_THRESH
- isAlmostFullOut  out  1  count >= ALMOST_FULL_THRESH
- dataCountOut  out  COUNT_WIDTH  current occupancy
- overflowOut  out  1  sticky: a write was dropped
- underflowOut  out  1  sticky: a read was rejected

Behaviour:
- Reset (rstIn=1 at a clock edge):
  - write pointer, read pointer and count go to 0;
  - rdDataOut=0, rdValidOut=0, overflowOut=0, underflowOut=0;
  - memory contents are not cleared.
  - Reset mid-operation discards all stored data; the first post-reset cycle accepts writes.
- All flags and dataCountOut are combinational from the registered count. They update the cycle after the causing edge.
  - Post-reset values: isEmptyOut=1, isFullOut=0, isAlmostEmptyOut=1, isAlmostFullOut=0.
- Read accepted (rdAcc) = rdEnIn & (count > 0). An empty-cycle write does not satisfy a same-cycle read.
- Write accepted (wrAcc) = wrEnIn & ((count < FIFO_DEPTH) | rdAcc). When full, a write is accepted only if a read is accepted in the same cycle.
- Count update:
  - +1 on wrAcc & !rdAcc;
  - -1 on rdAcc & !wrAcc;
  - unchanged on both or neither.
- Pointers:
  - each pointer advances by 1 on its accept;
  - each wraps from FIFO_DEPTH-1 to 0 (explicit compare, not modulo).
- Standard mode (FWFT_MODE=0):
  - on rdAcc, rdDataOut <= mem[rdPtr] at the same edge, so data is visible 1 cycle after the request;
  - rdValidOut is a 1-cycle pulse aligned with that data;
  - rdDataOut holds its value when there is no read.
- FWFT mode (FWFT_MODE=1):
  - rdDataOut = mem[rdPtr] combinationally; rdValidOut = !isEmptyOut;
  - rdEnIn with rdValidOut=1 consumes the head word, and the next word appears the following cycle;
  - a word written into an empty FIFO appears on rdDataOut 1 cycle after the write edge.
- Errors:
  - overflowOut is set on wrEnIn & !wrAcc; the dropped data is discarded and state is unchanged.
  - underflowOut is set on rdEnIn & !rdAcc.
  - Both flags are cleared by clrErrIn. A set in the same cycle takes priority over the clear.
- Simultaneous read and write:
  - when empty: the write is accepted, the read is rejected, underflowOut is set, and count becomes 1;
  - when full: both are accepted and count stays FIFO_DEPTH.
- Ordering is strict FIFO. No data is ever reordered or duplicated.

Test Plan:
1. Reset, then write 0x01..0x10 (16 words), then read 16 (FWFT=0) -> isFullOut=1 after the 16th write; reads return 0x01..0x10 in order, each 1 cycle after rdEnIn; isEmptyOut=1 at the end; overflowOut=0.
2. Fill to 16, then write 0xAA with no read -> overflowOut=1, dataCountOut stays 16, 0xAA never read back. Then pulse clrErrIn -> overflowOut=0.
3. Fill to 16, then assert wrEnIn+rdEnIn for 20 cycles with incrementing data -> count stays 16, isFullOut stays 1, output sequence is continuous with no gaps. Repeat across pointer wrap.
4. Empty FIFO, assert wrEnIn(0x55)+rdEnIn together -> underflowOut=1, dataCountOut=1; a read on the next cycle returns 0x55.
5. FWFT=1: write 0x3C into an empty FIFO -> rdValidOut=1 and rdDataOut=0x3C on the next cycle without rdEnIn. Pop -> rdValidOut=0.
6. Threshold sweep: step count 0->16->0 -> isAlmostEmptyOut=1 for count<=2; isAlmostFullOut=1 for count>=14. Assert rstIn at count=9 -> all outputs return to reset values on the next cycle.
